dcache_controller: RTL
======================

// Module: dcache_controller
// PURPOSE
//  Direct-mapped, write-through, no-write-allocate data-cache controller for the single-cycle RV32 core.
//  Sits between the core's load/store port and the external memory handshake.
//  Owns the tag/valid arrays and the data array.
//  Freezes the core through o_Stall on misses and on stores.
// PARAMETERS
//  ADDR_W    32  byte-address width
//  DATA_W    32  word width
//  LINES     16  number of cache lines (power of 2)
//  WORDS     4   words per line (power of 2)
// PORTS
//  i_Clk        in   1       single clock, rising edge
//  i_Rst_n      in   1       asynchronous, active-low reset
//  i_Req        in   1       core load/store valid this cycle
//  i_We         in   1       1=store, 0=load
//  i_Addr       in   ADDR_W  byte address (word aligned, [1:0] ignored)
//  i_WData      in   DATA_W  store data
//  i_Flush      in   1       invalidate all lines
//  o_RData      out  DATA_W  load data (combinational on hit)
//  o_Stall      out  1       hold the core's PC/state this cycle
//  o_MemReq     out  1       memory request valid
//  o_MemWe      out  1       memory write
//  o_MemAddr    out  ADDR_W  memory word address
//  o_MemWData   out  DATA_W  memory write data
//  i_MemAck     in   1       one word accepted/returned this cycle
//  i_MemRData   in   DATA_W  read data, valid with i_MemAck
// BEHAVIOUR
//  Address split: [1:0] byte offset; next log2(WORDS) bits are the word; next log2(LINES) bits are the index; the rest is the tag.
//  hit = valid[index] && tag[index]==addr tag. Evaluated combinationally, only in IDLE.
//  Reset (async): state=IDLE, all valid=0, word counter=0.
//   Outputs at reset: o_MemReq=0, o_MemWe=0, o_MemAddr=0, o_MemWData=0, o_Stall=0, o_RData=0.
//  FSM states: IDLE, REFILL, WRITE.
//   IDLE, i_Req & !i_We & hit -> o_RData=word, o_Stall=0, stay IDLE.
//   IDLE, i_Req & !i_We & miss -> o_Stall=1.
//     Latch tag/index, clear valid[index], counter=0, go to REFILL.
//   IDLE, i_Req & i_We -> o_Stall=1.
//     Latch addr, data and hit flag, go to WRITE.
//   REFILL: o_MemReq=1, o_MemWe=0, o_MemAddr={tag,index,counter,2'b00}.
//     On each i_MemAck: write i_MemRData into data[index][counter], then counter++.
//     On the ack of word WORDS-1: set tag[index], set valid[index]=1, go to IDLE.
//     The replay hits the next cycle.
//   WRITE: o_MemReq=1, o_MemWe=1, with the latched address and data.
//     On i_MemAck: if the latched hit flag is set, update the data word. Go to IDLE.
//  o_Stall = IDLE&i_Req&(i_We|!hit) | REFILL | WRITE&!i_MemAck.
//   The core commits the store in the WRITE ack cycle.
//   The store is never reissued.
//  i_MemAck is legal in the first cycle of o_MemReq. Ack while o_MemReq=0 is ignored.
//  o_MemReq, o_MemAddr and o_MemWData are registered.
//   They are stable until the ack, in every state.
//  Latency with zero-wait memory: load hit 0 stall cycles; load miss WORDS+1; store 1.
//  i_Flush: honoured only in IDLE with i_Req=0, clears all valid in one cycle. Ignored otherwise.
//  Same index, different tag: the line is replaced. There is no write-back, because the cache is write-through.
//  Reset mid-refill: the refill aborts and o_MemReq drops asynchronously.
//   The line stays invalid, because valid was cleared when the refill started.
//  Core inputs must stay stable while o_Stall=1. The controller uses its latched copies.
//  Counter width is log2(WORDS); it wraps to 0 on the last word.
// STRUCTURE
//  Package cache_pkg holds:
//   state encoding (IDLE/REFILL/WRITE)
//   derived widths OFF_W, IDX_W, TAG_W
//   default LINES/WORDS
//  Sub-module cache_data_array holds LINES*WORDS x DATA_W.
//   One asynchronous read port, one synchronous write port.
//  Tag and valid arrays are flops inside dcache_controller.
// TESTING
//  Run with LINES=16, WORDS=4, zero-wait memory unless stated.
//  1 Cold read 0x40 after reset -> 4 mem reads at 0x40/44/48/4C; o_Stall high 5 cycles; o_RData=mem[0x40].
//  2 Then read 0x44 -> no o_MemReq; o_Stall=0; o_RData=mem[0x44].
//  3 Store 0xDEADBEEF to 0x48 (hit) -> one mem write at 0x48; stall 1 cycle.
//    A following read of 0x48 returns 0xDEADBEEF with no mem traffic.
//  4 Store to 0x200 (miss) -> mem write only, no refill. A read of 0x200 then misses and refills.
//  5 Read 0x40 then 0x440 (both index 4) -> second refill replaces line 4.
//    A re-read of 0x40 misses again. With 3-cycle ack latency the load miss stalls 4x3+1=13 cycles.
//  6 Assert i_Rst_n=0 after 2 refill acks -> o_MemReq=0 immediately.
//    Re-reading 0x40 refills all 4 words. i_Flush in IDLE -> 0x44 misses next access.

Source files
------------

// File: rtl/cache_pkg.sv
// Shared constants and types for the direct-mapped write-through data cache.
// The address splits into tag | index | word | byte offset, and the widths below follow from LINES and WORDS.
package cache_pkg;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int LINES  = 16;
  localparam int WORDS  = 4;

  localparam int OFF_W  = $clog2(WORDS);
  localparam int IDX_W  = $clog2(LINES);
  localparam int TAG_W  = ADDR_W - 2 - OFF_W - IDX_W;
  localparam int AA_W   = IDX_W + OFF_W;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_REFILL = 2'd1,
    ST_WRITE  = 2'd2
  } state_e;

endpackage

// File: rtl/dcache_controller_if.sv
// Core load/store port plus the external memory handshake, bundled together.
//
// Handshake rules:
// - A core request (i_Req) holds all of its inputs stable while o_Stall=1.
// - A memory request (o_MemReq) holds o_MemWe, o_MemAddr and o_MemWData stable until the
//   cycle in which i_MemAck=1. That ack cycle transfers exactly one word.
// - i_MemAck may arrive in the first cycle of o_MemReq.
// - An ack seen while o_MemReq=0 has no effect.
interface dcache_controller_if;
  import cache_pkg::*;

  logic              i_Req;
  logic              i_We;
  logic [ADDR_W-1:0] i_Addr;
  logic [DATA_W-1:0] i_WData;
  logic              i_Flush;
  logic [DATA_W-1:0] o_RData;
  logic              o_Stall;
  logic              o_MemReq;
  logic              o_MemWe;
  logic [ADDR_W-1:0] o_MemAddr;
  logic [DATA_W-1:0] o_MemWData;
  logic              i_MemAck;
  logic [DATA_W-1:0] i_MemRData;

  modport slave (
    input  i_Req, i_We, i_Addr, i_WData, i_Flush, i_MemAck, i_MemRData,
    output o_RData, o_Stall, o_MemReq, o_MemWe, o_MemAddr, o_MemWData
  );

  modport master (
    output i_Req, i_We, i_Addr, i_WData, i_Flush, i_MemAck, i_MemRData,
    input  o_RData, o_Stall, o_MemReq, o_MemWe, o_MemAddr, o_MemWData
  );

endinterface

// File: rtl/cache_data_array.sv
// Cache data storage with LINES*WORDS words.
// It has one asynchronous read port and one synchronous write port, addressed as {index, word}.
module cache_data_array
  import cache_pkg::*;
(
  input  logic              clk,
  input  logic              we,
  input  logic [AA_W-1:0]   waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [AA_W-1:0]   raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem_q [LINES*WORDS];

  // Write one word per cycle. Contents are qualified by the valid bits, so no reset is needed.
  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/dcache_controller.sv
// Direct-mapped, write-through, no-write-allocate data-cache controller.
// Loads that hit return data in the same cycle.
// A load miss refills the whole line one word per ack and then replays as a hit.
// A store always writes memory, and updates the line only when it was already present.
module dcache_controller
  import cache_pkg::*;
(
  input  logic   i_Clk,
  input  logic   i_Rst_n,
  dcache_controller_if.slave bus,
  output state_e o_dbg_state
);

  state_e            state_q, state_d;
  logic [OFF_W-1:0]  cnt_q, cnt_d, cnt_inc;
  logic              st_hit_q, st_hit_d;
  logic [LINES-1:0]  valid_q, valid_d;
  logic [TAG_W-1:0]  tag_q [LINES];
  logic [TAG_W-1:0]  tag_d [LINES];
  logic              mem_req_q, mem_req_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;

  logic              hit, ack, stall;
  logic [DATA_W-1:0] rdata, arr_rdata, arr_wdata;
  logic              arr_we;
  logic [AA_W-1:0]   arr_waddr;

  logic [TAG_W-1:0]  a_tag, m_tag;
  logic [IDX_W-1:0]  a_idx, m_idx;
  logic [OFF_W-1:0]  a_word, m_word;
  logic [1:0]        unused_byte_off;

  // Field views of the core address and of the in-flight memory address
  assign a_tag  = bus.i_Addr[ADDR_W-1 -: TAG_W];
  assign a_idx  = bus.i_Addr[2+OFF_W +: IDX_W];
  assign a_word = bus.i_Addr[2 +: OFF_W];
  assign m_tag  = mem_addr_q[ADDR_W-1 -: TAG_W];
  assign m_idx  = mem_addr_q[2+OFF_W +: IDX_W];
  assign m_word = mem_addr_q[2 +: OFF_W];
  assign unused_byte_off = bus.i_Addr[1:0];

  assign hit     = valid_q[a_idx] && (tag_q[a_idx] == a_tag);
  assign ack     = bus.i_MemAck && mem_req_q;
  assign cnt_inc = cnt_q + 1'b1;

  cache_data_array u_data (
    .clk   (i_Clk),
    .we    (arr_we),
    .waddr (arr_waddr),
    .wdata (arr_wdata),
    .raddr ({a_idx, a_word}),
    .rdata (arr_rdata)
  );

  // Next-state, next memory command and core-facing outputs
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    st_hit_d    = st_hit_q;
    valid_d     = valid_q;
    tag_d       = tag_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    stall       = 1'b0;
    rdata       = '0;
    arr_we      = 1'b0;
    arr_waddr   = {m_idx, cnt_q};
    arr_wdata   = bus.i_MemRData;

    case (state_q)
      ST_IDLE: begin
        if (bus.i_Req) begin
          if (bus.i_We) begin
            // Store: write through to memory and remember whether the line holds this address
            stall       = 1'b1;
            st_hit_d    = hit;
            mem_req_d   = 1'b1;
            mem_we_d    = 1'b1;
            mem_addr_d  = {bus.i_Addr[ADDR_W-1:2], 2'b00};
            mem_wdata_d = bus.i_WData;
            state_d     = ST_WRITE;
          end else if (hit) begin
            rdata = arr_rdata;
          end else begin
            // Invalidate first, so an aborted refill never leaves a half-filled line marked valid
            stall          = 1'b1;
            valid_d[a_idx] = 1'b0;
            cnt_d          = '0;
            mem_req_d      = 1'b1;
            mem_we_d       = 1'b0;
            mem_addr_d     = {a_tag, a_idx, {OFF_W{1'b0}}, 2'b00};
            state_d        = ST_REFILL;
          end
        end else if (bus.i_Flush) begin
          valid_d = '0;
        end
      end

      ST_REFILL: begin
        stall = 1'b1;
        if (ack) begin
          arr_we = 1'b1;
          cnt_d  = cnt_inc;
          if (cnt_inc == '0) begin
            tag_d[m_idx]   = m_tag;
            valid_d[m_idx] = 1'b1;
            mem_req_d      = 1'b0;
            mem_addr_d     = '0;
            state_d        = ST_IDLE;
          end else begin
            mem_addr_d = {m_tag, m_idx, cnt_inc, 2'b00};
          end
        end
      end

      ST_WRITE: begin
        stall = !ack;
        if (ack) begin
          if (st_hit_q) begin
            arr_we    = 1'b1;
            arr_waddr = {m_idx, m_word};
            arr_wdata = mem_wdata_q;
          end
          mem_req_d   = 1'b0;
          mem_we_d    = 1'b0;
          mem_addr_d  = '0;
          mem_wdata_d = '0;
          state_d     = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // Control state and the registered memory command; reset drops o_MemReq immediately
  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      st_hit_q    <= 1'b0;
      valid_q     <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      st_hit_q    <= st_hit_d;
      valid_q     <= valid_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  // Tags are only meaningful when the matching valid bit is set, so they need no reset
  always_ff @(posedge i_Clk) begin
    tag_q <= tag_d;
  end

  assign bus.o_RData    = rdata;
  assign bus.o_Stall    = stall;
  assign bus.o_MemReq   = mem_req_q;
  assign bus.o_MemWe    = mem_we_q;
  assign bus.o_MemAddr  = mem_addr_q;
  assign bus.o_MemWData = mem_wdata_q;
  assign o_dbg_state    = state_q;

endmodule
